// File: rtl/cnt_pkg.sv
// Shared types, constants and helpers for the up/down modulo-N counter.
// Imported by the prescaler and the counter top.
package cnt_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   localparam logic CNT_DIR_UP   = 1'b1;
   localparam logic CNT_DIR_DOWN = 1'b0;

   // Bits needed to hold 0..n-1, never less than one so a divide-by-1 still has a register.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'(1) << w) < 64'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable divider: emits a one-cycle tick every PRESCALE enabled cycles.
// restart forces the phase back to zero and suppresses the tick for that cycle.
module cnt_prescaler
   import cnt_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int            PW   = clog2_min1(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;
   logic          at_last;

   assign at_last = (phase == LAST);
   assign tick    = en & ~restart & at_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (en) begin
         if (at_last) phase <= '0;
         else         phase <= phase + PW'(1);
      end
   end

endmodule

// File: rtl/cnt_updown_modn.sv
// Parametrised up/down modulo-N counter with clear, clamped load, wrap/saturate,
// prescaled stepping, one-cycle terminal-count pulse and sticky boundary flag.
module cnt_updown_modn
   import cnt_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 7,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("cnt_updown_modn: WIDTH must be 1..16");
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("cnt_updown_modn: MODULUS must be 2..2**WIDTH");
   end
   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("cnt_updown_modn: PRESCALE must be 1..65535");
   end

   // One extra bit so MODULUS == 2**WIDTH is still representable.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_V = MAX_W[WIDTH-1:0];

   logic             tick;
   logic             restart;
   cnt_mode_e        mode;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

   assign restart = clr | load;
   assign mode    = cnt_mode_e'(sat_mode);

   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (restart),
      .tick    (tick)
   );

   assign at_top       = ({1'b0, count} == MAX_W);
   assign at_bot       = (count == '0);
   assign load_clamped = ({1'b0, load_val} < MOD_W) ? load_val : MAX_V;

   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      ovf_nxt   = ovf;
      if (clr) begin
         count_nxt = '0;
         ovf_nxt   = 1'b0;
      end else if (load) begin
         count_nxt = load_clamped;
      end else if (tick) begin
         if (up == CNT_DIR_UP) begin
            if (at_top) begin
               tc_nxt    = 1'b1;
               ovf_nxt   = 1'b1;
               count_nxt = (mode == CNT_WRAP) ? '0 : MAX_V;
            end else begin
               count_nxt = count + WIDTH'(1);
            end
         end else begin
            if (at_bot) begin
               tc_nxt    = 1'b1;
               ovf_nxt   = 1'b1;
               count_nxt = (mode == CNT_WRAP) ? MAX_V : '0;
            end else begin
               count_nxt = count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_cnt_updown_modn.sv
// Bench for cnt_updown_modn: a default instance and a prescaled mod-10 instance,
// expected results queued at drive time and compared one edge later.
module tb_cnt_updown_modn;

   localparam int WA = 3, MA = 7;
   localparam int WB = 4, MB = 10, PB = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_a, en_a, up_a, sat_a, clr_a, load_a, tc_a, ovf_a;
   logic [WA-1:0] lv_a, count_a;
   logic          reset_b, en_b, up_b, sat_b, clr_b, load_b, tc_b, ovf_b;
   logic [WB-1:0] lv_b, count_b;

   cnt_updown_modn #(.WIDTH(WA), .MODULUS(MA), .PRESCALE(1)) u_dut_a (
      .clk(clk), .reset(reset_a), .en(en_a), .up(up_a), .sat_mode(sat_a),
      .clr(clr_a), .load(load_a), .load_val(lv_a),
      .count(count_a), .tc(tc_a), .ovf(ovf_a));

   cnt_updown_modn #(.WIDTH(WB), .MODULUS(MB), .PRESCALE(PB)) u_dut_b (
      .clk(clk), .reset(reset_b), .en(en_b), .up(up_b), .sat_mode(sat_b),
      .clr(clr_b), .load(load_b), .load_val(lv_b),
      .count(count_b), .tc(tc_b), .ovf(ovf_b));

   typedef struct {
      string tag;
      int    cnt;
      bit    tc;
      bit    ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_tot = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_a(input bit e, u, s, c, l, input int lv,
                          input string tag, input int ec, input bit et, input bit eo);
      @(negedge clk);
      en_a = e; up_a = u; sat_a = s; clr_a = c; load_a = l; lv_a = lv[WA-1:0];
      q_a.push_back('{tag, ec, et, eo});
   endtask

   task automatic drive_b(input bit e, u, s, c, l, input int lv,
                          input string tag, input int ec, input bit et, input bit eo);
      @(negedge clk);
      en_b = e; up_b = u; sat_b = s; clr_b = c; load_b = l; lv_b = lv[WB-1:0];
      q_b.push_back('{tag, ec, et, eo});
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk({e.tag, "/a_cnt"}, 32'(count_a), 32'(e.cnt));
            chk({e.tag, "/a_tc"},  32'(tc_a),    32'(e.tc));
            chk({e.tag, "/a_ovf"}, 32'(ovf_a),   32'(e.ovf));
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk({e.tag, "/b_cnt"}, 32'(count_b), 32'(e.cnt));
            chk({e.tag, "/b_tc"},  32'(tc_b),    32'(e.tc));
            chk({e.tag, "/b_ovf"}, 32'(ovf_b),   32'(e.ovf));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int t1_cnt[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
      int t5_cnt[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
      bit t5_en[5]  = '{1, 1, 0, 0, 1};
      int t5_gap[5] = '{3, 3, 3, 3, 4};
      int mc;
      bit mt, mo;

      reset_a = 1'b1; en_a = 0; up_a = 0; sat_a = 0; clr_a = 0; load_a = 0; lv_a = '0;
      reset_b = 1'b1; en_b = 0; up_b = 0; sat_b = 0; clr_b = 0; load_b = 0; lv_b = '0;
      #1;
      chk("rst/a_cnt", 32'(count_a), 0);
      chk("rst/a_tc",  32'(tc_a),    0);
      chk("rst/a_ovf", 32'(ovf_a),   0);
      chk("rst/b_cnt", 32'(count_b), 0);
      chk("rst/b_tc",  32'(tc_b),    0);
      chk("rst/b_ovf", 32'(ovf_b),   0);
      @(negedge clk);
      reset_a = 1'b0;
      reset_b = 1'b0;

      // Up-count wrap through MODULUS-1.
      for (int i = 0; i < 8; i++)
         drive_a(1, 1, 0, 0, 0, 0, "t1_up", t1_cnt[i], i == 6, i >= 6);

      // Down-count wrap from zero.
      drive_a(0, 0, 0, 0, 1, 0, "t2_load0", 0, 0, 1);
      drive_a(1, 0, 0, 0, 0, 0, "t2_dn", 6, 1, 1);
      drive_a(1, 0, 0, 0, 0, 0, "t2_dn", 5, 0, 1);
      drive_a(1, 0, 0, 0, 0, 0, "t2_dn", 4, 0, 1);

      // Saturation at the top, then clear.
      drive_a(0, 1, 1, 0, 1, 5, "t3_load5", 5, 0, 1);
      drive_a(1, 1, 1, 0, 0, 0, "t3_sat", 6, 0, 1);
      drive_a(1, 1, 1, 0, 0, 0, "t3_sat", 6, 1, 1);
      drive_a(1, 1, 1, 0, 0, 0, "t3_sat", 6, 1, 1);
      drive_a(1, 1, 1, 1, 0, 0, "t3_clr", 0, 0, 0);
      drive_a(0, 1, 1, 0, 0, 0, "t3_hold", 0, 0, 0);

      // Load clamp and priority.
      drive_a(0, 1, 0, 0, 1, 7, "t4_clamp", 6, 0, 0);
      drive_a(0, 1, 0, 1, 1, 3, "t4_clr_ld", 0, 0, 0);
      drive_a(1, 1, 0, 0, 1, 2, "t4_ld_en", 2, 0, 0);
      drive_a(1, 1, 0, 0, 1, 6, "t4_ld_top", 6, 0, 0);
      drive_a(1, 1, 0, 0, 0, 0, "t4_wrap", 0, 1, 1);
      drive_a(1, 0, 1, 1, 0, 0, "t4_clr2", 0, 0, 0);
      drive_a(1, 0, 1, 0, 0, 0, "t4_sat_bot", 0, 1, 1);
      drive_a(1, 1, 1, 0, 0, 0, "t4_up", 1, 0, 1);
      drive_a(1, 1, 0, 0, 0, 0, "t6_pre", 2, 0, 1);
      drive_a(1, 1, 0, 0, 0, 0, "t6_pre", 3, 0, 1);
      drive_a(1, 1, 0, 0, 0, 0, "t6_pre", 4, 0, 1);

      // Asynchronous reset between edges.
      @(negedge clk);
      #2;
      reset_a = 1'b1;
      #1;
      chk("t6_arst/a_cnt", 32'(count_a), 0);
      chk("t6_arst/a_tc",  32'(tc_a),    0);
      chk("t6_arst/a_ovf", 32'(ovf_a),   0);
      en_a = 1'b0;
      @(negedge clk);
      reset_a = 1'b0;
      drive_a(1, 1, 0, 0, 0, 0, "t6_first", 1, 0, 0);

      // Randomised traffic against an arithmetic model.
      drive_a(0, 0, 0, 1, 0, 0, "rnd_clr", 0, 0, 0);
      mc = 0; mo = 0;
      for (int i = 0; i < 300; i++) begin
         bit e, u, s, c, l;
         int lv;
         e  = ($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         c  = ($urandom_range(0, 29) == 0);
         l  = ($urandom_range(0, 14) == 0);
         lv = int'($urandom_range(0, 7));
         mt = 0;
         if (c) begin
            mc = 0; mo = 0;
         end else if (l) begin
            mc = (lv < MA) ? lv : MA - 1;
         end else if (e) begin
            if (u) begin
               if (mc == MA - 1) begin mt = 1; mo = 1; if (!s) mc = 0; end
               else mc = (mc + 1) % MA;
            end else begin
               if (mc == 0) begin mt = 1; mo = 1; if (!s) mc = MA - 1; end
               else mc = (mc + MA - 1) % MA;
            end
         end
         drive_a(e, u, s, c, l, lv, "rnd", mc, mt, mo);
      end
      @(negedge clk);
      en_a = 0; clr_a = 0; load_a = 0;

      // Prescaled instance: step every third enabled cycle, en gap delays it.
      for (int i = 0; i < 9; i++)
         drive_b(1, 1, 0, 0, 0, 0, "t5_pre", t5_cnt[i], 0, 0);
      for (int i = 0; i < 5; i++)
         drive_b(t5_en[i], 1, 0, 0, 0, 0, "t5_gap", t5_gap[i], 0, 0);
      drive_b(0, 1, 0, 0, 1, 9, "t5_load9", 9, 0, 0);
      drive_b(1, 1, 0, 0, 0, 0, "t5_top", 9, 0, 0);
      drive_b(1, 1, 0, 0, 0, 0, "t5_top", 9, 0, 0);
      drive_b(1, 1, 0, 0, 0, 0, "t5_wrap", 0, 1, 1);
      drive_b(0, 1, 0, 0, 1, 15, "t5_clamp", 9, 0, 1);
      drive_b(1, 1, 0, 0, 0, 0, "t6b_pre", 9, 0, 1);
      drive_b(1, 1, 0, 0, 0, 0, "t6b_pre", 9, 0, 1);

      @(negedge clk);
      #2;
      reset_b = 1'b1;
      #1;
      chk("t6b_arst/b_cnt", 32'(count_b), 0);
      chk("t6b_arst/b_tc",  32'(tc_b),    0);
      chk("t6b_arst/b_ovf", 32'(ovf_b),   0);
      en_b = 1'b0;
      @(negedge clk);
      reset_b = 1'b0;
      drive_b(1, 1, 0, 0, 0, 0, "t6b_post", 0, 0, 0);
      drive_b(1, 1, 0, 0, 0, 0, "t6b_post", 0, 0, 0);
      drive_b(1, 1, 0, 0, 0, 0, "t6b_post", 1, 0, 0);

      @(negedge clk);
      en_b = 1'b0;
      @(negedge clk);
      chk("q_drain", 32'(q_a.size() + q_b.size()), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
